rtype_control_sequencer: RTL



---
 rtl/rtype_control_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rtype_control_sequencer.sv
// Hardwired T0..T6 sequencer for register-register ALU instructions on the
// single-bus datapath: fetch with memory wait, decode, operands, ALU, HI/LO.
module rtype_control_sequencer #(
    parameter int unsigned     NUM_REGS    = 16,
    parameter int unsigned     OP_W        = 5,
    parameter int unsigned     RF_W        = 4,
    parameter logic [OP_W-1:0] RTYPE_MAX   = 5'b01110,
    parameter logic [OP_W-1:0] MUL_OP      = 5'b01111,
    parameter logic [OP_W-1:0] DIV_OP      = 5'b10000,
    parameter int unsigned     MEM_TIMEOUT = 8
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                start,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                ZLowout,
    output logic                ZHighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                ZHighIn,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [OP_W-1:0]     alu_op,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                timeout
);

    localparam int unsigned         CW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]       WAIT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [RF_W:0]       REG_LIM   = (RF_W + 1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE       = NUM_REGS'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_FAULT
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [OP_W-1:0] op_q;
    logic [RF_W-1:0] ra_q;
    logic [RF_W-1:0] rc_q;
    logic            md_q;

    logic [OP_W-1:0] opcode;
    logic [RF_W-1:0] ra;
    logic [RF_W-1:0] rb;
    logic [RF_W-1:0] rc;
    logic            is_md;
    logic            bad;
    logic            unused_ir;

    assign opcode    = ir[31 -: OP_W];
    assign ra        = ir[31-OP_W -: RF_W];
    assign rb        = ir[31-OP_W-RF_W -: RF_W];
    assign rc        = ir[31-OP_W-2*RF_W -: RF_W];
    assign unused_ir = ^ir[31-OP_W-3*RF_W:0];

    assign is_md = (opcode == MUL_OP) || (opcode == DIV_OP);
    assign bad   = ((opcode > RTYPE_MAX) && !is_md)
                 || ({1'b0, ra} >= REG_LIM)
                 || ({1'b0, rb} >= REG_LIM)
                 || ({1'b0, rc} >= REG_LIM);

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
            op_q     <= '0;
            ra_q     <= '0;
            rc_q     <= '0;
            md_q     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) state <= S_T0;
                S_T0: begin
                    wait_cnt <= '0;
                    state    <= S_T1;
                end
                S_T1: begin
                    if (mem_ready) begin
                        state <= S_T2;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout <= 1'b1;
                        state   <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    if (bad) begin
                        illegal <= 1'b1;
                        state   <= S_FAULT;
                    end else begin
                        op_q  <= opcode;
                        ra_q  <= ra;
                        rc_q  <= rc;
                        md_q  <= is_md;
                        state <= S_T4;
                    end
                end
                S_T4: state <= S_T5;
                S_T5: state <= md_q ? S_T6 : S_IDLE;
                S_T6: state <= S_IDLE;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes follow the state; T1 fetch completion and T3 decode gate theirs.
    always_comb begin
        PCout    = 1'b0;
        ZLowout  = 1'b0;
        ZHighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        alu_op   = '0;
        reg_out  = '0;
        reg_in   = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_T0: begin
                busy   = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                busy  = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) begin
                    ZLowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            S_T2: begin
                busy   = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                busy = 1'b1;
                if (!bad) begin
                    reg_out = ONE << rb;
                    Yin     = 1'b1;
                end
            end
            S_T4: begin
                busy    = 1'b1;
                reg_out = ONE << rc_q;
                alu_op  = op_q;
                ZLowIn  = 1'b1;
                ZHighIn = md_q;
            end
            S_T5: begin
                busy    = 1'b1;
                ZLowout = 1'b1;
                if (md_q) begin
                    LOin = 1'b1;
                end else begin
                    reg_in = ONE << ra_q;
                    done   = 1'b1;
                end
            end
            S_T6: begin
                busy     = 1'b1;
                ZHighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
